lab2v1_mem_test_master: RTL

LAB2V1_MEM_TEST_MASTER -- requirements
Module: lab2v1_mem_test_master

---
 rtl/lab2v1_mem_test_pkg.sv | 20 ++
 rtl/lab2v1_mem_test_master_if.sv | 23 ++
 rtl/lab2v1_pattern_gen.sv | 55 +++++
 rtl/lab2v1_mem_test_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lab2v1_mem_test_pkg.sv
// Shared types and constants for the memory test master.
package lab2v1_mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    FINISH    = 3'd4
  } state_e;

  localparam logic [31:0] PAT_XOR   = 32'hA5A5_A5A5;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/lab2v1_mem_test_master_if.sv
// Avalon-MM master bus between the memory test master and its target memory.
interface lab2v1_mem_test_master_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] av_address;
  logic              av_write;
  logic              av_read;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic              av_waitrequest;
  logic              av_readdatavalid;
  logic [31:0]       av_readdata;

  modport master (
    output av_address, av_write, av_read, av_writedata, av_byteenable,
    input  av_waitrequest, av_readdatavalid, av_readdata
  );

  modport slave (
    input  av_address, av_write, av_read, av_writedata, av_byteenable,
    output av_waitrequest, av_readdatavalid, av_readdata
  );
endinterface

// File: rtl/lab2v1_pattern_gen.sv
// Test pattern source; LFSR_PATTERN_EN selects a Galois LFSR, otherwise address XOR PAT_XOR.
// addr is the address of the word the pattern will belong to after this edge.
module lab2v1_pattern_gen
  import lab2v1_mem_test_pkg::*;
#(
  parameter int          ADDR_W = 14,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reseed,
  input  logic              advance,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       pattern
);
  logic [31:0] pattern_d, pattern_q;
  logic        unused_s;

`ifdef LFSR_PATTERN_EN
  assign unused_s = ^addr;

  // Reseed has priority so a run always starts from SEED.
  always_comb begin
    if (reseed) begin
      pattern_d = SEED;
    end else if (advance) begin
      pattern_d = lfsr_step(pattern_q);
    end else begin
      pattern_d = pattern_q;
    end
  end
`else
  assign unused_s = ^SEED;

  // Pattern tracks the address being loaded on reseed or advance.
  always_comb begin
    if (reseed || advance) begin
      pattern_d = {{(32-ADDR_W){1'b0}}, addr} ^ PAT_XOR;
    end else begin
      pattern_d = pattern_q;
    end
  end
`endif

  // Pattern register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= 32'h0000_0000;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;
endmodule

// File: rtl/lab2v1_mem_test_master.sv
// Memory test master: writes a pattern to len words from base, reads them back and counts mismatches.
// Define LFSR_PATTERN_EN to use the LFSR pattern instead of the address-XOR pattern.
module lab2v1_mem_test_master
  import lab2v1_mem_test_pkg::*;
#(
  parameter int          ADDR_W = 14,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  lab2v1_mem_test_master_if.master av
);
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, first_err_addr_q, first_err_addr_d;
  logic [ADDR_W:0]   len_q, len_d, remain_q, remain_d, len_clamp_s;
  logic [15:0]       err_count_q, err_count_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              first_seen_q, first_seen_d;
  logic              av_write_q, av_write_d, av_read_q, av_read_d;
  logic              reseed_s, advance_s;
  logic [31:0]       pattern_s;

  assign len_clamp_s = (len > LEN_MAX) ? LEN_MAX : len;

  lab2v1_pattern_gen #(.ADDR_W(ADDR_W), .SEED(SEED)) u_pattern_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .reseed  (reseed_s),
    .advance (advance_s),
    .addr    (addr_d),
    .pattern (pattern_s)
  );

  // Next-state and command logic; strobes are computed a cycle ahead so they leave flops.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    len_d            = len_q;
    addr_d           = addr_q;
    remain_d         = remain_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_seen_d     = first_seen_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    av_write_d       = av_write_q;
    av_read_d        = av_read_q;
    reseed_s         = 1'b0;
    advance_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d           = base;
          len_d            = len_clamp_s;
          addr_d           = base;
          remain_d         = len_clamp_s;
          err_count_d      = 16'h0000;
          first_err_addr_d = {ADDR_W{1'b0}};
          first_seen_d     = 1'b0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
          reseed_s         = 1'b1;
          if (len_clamp_s == LEN_ZERO) begin
            state_d = FINISH;
          end else begin
            av_write_d = 1'b1;
            state_d    = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!av.av_waitrequest) begin
          if (remain_q == LEN_ONE) begin
            addr_d     = base_q;
            remain_d   = len_q;
            reseed_s   = 1'b1;
            av_write_d = 1'b0;
            av_read_d  = 1'b1;
            state_d    = READ_REQ;
          end else begin
            addr_d    = addr_q + ADDR_ONE;
            remain_d  = remain_q - LEN_ONE;
            advance_s = 1'b1;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ_REQ: begin
        if (!av.av_waitrequest) begin
          av_read_d = 1'b0;
          state_d   = READ_WAIT;
        end else begin
          state_d = READ_REQ;
        end
      end
      READ_WAIT: begin
        if (av.av_readdatavalid) begin
          if (av.av_readdata != pattern_s) begin
            err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
            if (!first_seen_q) begin
              first_seen_d     = 1'b1;
              first_err_addr_d = addr_q;
            end else begin
              first_err_addr_d = first_err_addr_q;
            end
          end else begin
            err_count_d = err_count_q;
          end
          if (remain_q == LEN_ONE) begin
            state_d = FINISH;
          end else begin
            addr_d    = addr_q + ADDR_ONE;
            remain_d  = remain_q - LEN_ONE;
            advance_s = 1'b1;
            av_read_d = 1'b1;
            state_d   = READ_REQ;
          end
        end else begin
          state_d = READ_WAIT;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == 16'h0000);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        av_write_d = 1'b0;
        av_read_d  = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      base_q           <= {ADDR_W{1'b0}};
      len_q            <= LEN_ZERO;
      addr_q           <= {ADDR_W{1'b0}};
      remain_q         <= LEN_ZERO;
      err_count_q      <= 16'h0000;
      first_err_addr_q <= {ADDR_W{1'b0}};
      first_seen_q     <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      av_write_q       <= 1'b0;
      av_read_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      len_q            <= len_d;
      addr_q           <= addr_d;
      remain_q         <= remain_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_seen_q     <= first_seen_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      av_write_q       <= av_write_d;
      av_read_q        <= av_read_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_err_addr   = first_err_addr_q;
  assign av.av_address    = addr_q;
  assign av.av_write      = av_write_q;
  assign av.av_read       = av_read_q;
  assign av.av_writedata  = pattern_s;
  assign av.av_byteenable = 4'hF;
endmodule
